// File: rtl/puncture_if.sv
// puncture_if: control and handshake bundle for the puncturer.
//   init      : one-cycle frame-start pulse (latches rate, clears state)
//   rate      : 0=1/2, 1=2/3, 2=3/4, 3=5/6, sampled only with init
//   in_valid  / in_bits / in_ready   : coded-pair input, in_bits[0]=A, [1]=B
//   out_valid / out_bit  / out_ready : punctured serial bit output
// slave is the puncturer side, master is the driver/consumer side.
interface puncture_if;
  logic       init;
  logic [1:0] rate;
  logic       in_valid;
  logic [1:0] in_bits;
  logic       in_ready;
  logic       out_valid;
  logic       out_bit;
  logic       out_ready;

  modport slave (
    input  init, rate, in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bit
  );

  modport master (
    output init, rate, in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bit
  );
endinterface

// File: rtl/puncture.sv
// puncture: 802.11 puncturer following the rate-1/2 convolutional encoder.
// Accepts one coded pair (A,B) per handshake, drops bits according to the
// latched code rate and phase, and serialises the survivors through a
// 4-bit elastic buffer, A before B.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : puncture_if.slave (init, rate, input pair, output bit handshakes)
module puncture (
  input logic      clk,
  input logic      rst,
  puncture_if.slave bus
);

  logic [1:0] r_rate;
  logic [2:0] r_phase;
  logic [2:0] r_cnt;
  logic [3:0] r_mem;     // r_mem[0] is the head bit

  logic       w_in_ready;
  logic       w_push;
  logic       w_pop;
  logic       w_keep_a;
  logic       w_keep_b;
  logic [2:0] w_kept;
  logic [2:0] w_last;
  logic [2:0] w_base;
  logic [2:0] w_pos_b;
  logic [2:0] w_cnt_nxt;
  logic [3:0] w_mem_nxt;

  // in_ready depends only on the registered count, never on out_ready.
  assign w_in_ready = (r_cnt <= 3'd2);
  assign w_push     = bus.in_valid & w_in_ready & ~bus.init;
  assign w_pop      = (r_cnt != 3'd0) & bus.out_ready;

  // Every pattern keeps both bits at phase 0, A only on odd phases and
  // B only on even nonzero phases; the rate only sets the wrap point.
  assign w_keep_a = (r_phase == 3'd0) | r_phase[0];
  assign w_keep_b = ~r_phase[0];

  always_comb begin
    w_last = 3'd0;
    case (r_rate)
      2'd0: w_last = 3'd0;
      2'd1: w_last = 3'd1;
      2'd2: w_last = 3'd2;
      2'd3: w_last = 3'd4;
      default: w_last = 3'd0;
    endcase
  end

  assign w_kept    = w_push ? ({2'b00, w_keep_a} + {2'b00, w_keep_b}) : 3'd0;
  assign w_cnt_nxt = r_cnt + w_kept - {2'b00, w_pop};

  // New bits land just past the surviving entries after this cycle's pop.
  assign w_base  = r_cnt - {2'b00, w_pop};
  assign w_pos_b = w_base + {2'b00, w_keep_a};

  always_comb begin
    w_mem_nxt = w_pop ? {1'b0, r_mem[3:1]} : r_mem;
    for (int i = 0; i < 4; i++) begin
      if (w_push && w_keep_a && (w_base == 3'(i)))
        w_mem_nxt[i] = bus.in_bits[0];
      if (w_push && w_keep_b && (w_pos_b == 3'(i)))
        w_mem_nxt[i] = bus.in_bits[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rate  <= 2'd0;
      r_phase <= 3'd0;
      r_cnt   <= 3'd0;
      r_mem   <= 4'd0;
    end else if (bus.init) begin
      // Buffered bits are discarded by clearing the count only.
      r_rate  <= bus.rate;
      r_phase <= 3'd0;
      r_cnt   <= 3'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_mem <= w_mem_nxt;
      if (w_push)
        r_phase <= (r_phase == w_last) ? 3'd0 : r_phase + 3'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_cnt != 3'd0);
  assign bus.out_bit   = r_mem[0];

endmodule
